avalon_mem_master: RTL

- Parametrised successor to the CPU's fixed 32-bit Avalon bus master.
- Sits between the CPU datapath (fetch/load/store requests) and the Avalon memory-mapped bus.
- Generalises data width; adds byte/half/word sizing with lane steering, sign/zero extension, misalignment detection and a single-outstanding request/response handshake.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/lane_steer.sv | 46 ++++
 rtl/avalon_mem_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU-side Avalon memory master and its
// lane steering logic (also intended for reuse by the future cache).
package mem_pkg;

  // Access size encoding as presented by the CPU datapath; 2'd3 is illegal
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Byte-lane mask for an access at lane offset 0
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = 4'b0001;
      SIZE_HALF: size_mask = 4'b0011;
      SIZE_WORD: size_mask = 4'b1111;
      default:   size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lane_steer.sv
// Combinational lane steering: store data replication, byteenable generation
// and load extraction with sign/zero extension for a DATA_W-wide bus.
module lane_steer
  import mem_pkg::*;
#(
  parameter  int DATA_W    = 32,
  localparam int NLANES    = DATA_W / 8,
  localparam int LANE_BITS = $clog2(DATA_W / 8)
) (
  input  logic [LANE_BITS-1:0] off,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [31:0]          wdata,
  input  logic [DATA_W-1:0]    rdata_bus,
  output logic [DATA_W-1:0]    wdata_bus,
  output logic [NLANES-1:0]    be,
  output logic [31:0]          rdata
);

  logic [DATA_W-1:0] shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Replicate store data at its own size so byte 0 lands on every aligned lane
  always_comb begin
    case (size)
      SIZE_BYTE: wdata_bus = {NLANES{wdata[7:0]}};
      SIZE_HALF: wdata_bus = {(NLANES / 2){wdata[15:0]}};
      default:   wdata_bus = {(NLANES / 4){wdata}};
    endcase
    be = NLANES'(size_mask(size)) << off;
  end

  // Bring the addressed lane down to bit 0, truncate to size, then extend
  always_comb begin
    shifted = rdata_bus >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (size)
      SIZE_BYTE: rdata = sign_ext ? 32'(byte_s) : 32'(shifted[7:0]);
      SIZE_HALF: rdata = sign_ext ? 32'(half_s) : 32'(shifted[15:0]);
      default:   rdata = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// CPU-to-Avalon memory master: one outstanding request, byte/half/word
// sizing, misalignment detection and registered bus outputs.
// Optional feature: define AVALON_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES consecutive waitrequest cycles with an error response.
module avalon_mem_master
  import mem_pkg::*;
#(
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int NLANES         = DATA_W / 8,
  localparam int LANE_BITS      = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [NLANES-1:0] byteenable,
  input  logic [DATA_W-1:0] readdata
);

  if (DATA_W < 32 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("DATA_W must be a power of two no smaller than 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [NLANES-1:0]   byteenable_q, byteenable_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [LANE_BITS-1:0] off_q, off_d;
`ifdef AVALON_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic                 bad_req;
  logic [LANE_BITS-1:0] ls_off;
  logic [1:0]           ls_size;
  logic [DATA_W-1:0]    ls_wdata;
  logic [NLANES-1:0]    ls_be;
  logic [31:0]          ls_rdata;

  // While idle the steering sees the incoming request; afterwards the latched one
  assign ls_off  = (state_q == IDLE) ? req_addr[LANE_BITS-1:0] : off_q;
  assign ls_size = (state_q == IDLE) ? req_size : size_q;
  assign bad_req = (req_size == 2'd3)
                || (req_size == SIZE_HALF && req_addr[0])
                || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);

  lane_steer #(.DATA_W(DATA_W)) u_lane_steer (
    .off       (ls_off),
    .size      (ls_size),
    .sign_ext  (signed_q),
    .wdata     (req_wdata),
    .rdata_bus (readdata),
    .wdata_bus (ls_wdata),
    .be        (ls_be),
    .rdata     (ls_rdata)
  );

  // Next-state and next-output computation for the request/bus FSM
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
`ifdef AVALON_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          signed_d    = req_signed;
          off_d       = req_addr[LANE_BITS-1:0];
          if (bad_req) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d      = BUS;
            address_d    = {req_addr[ADDR_W-1:LANE_BITS], {LANE_BITS{1'b0}}};
            read_d       = ~req_write;
            write_d      = req_write;
            writedata_d  = ls_wdata;
            byteenable_d = ls_be;
`ifdef AVALON_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = RDATA;
          end
        end
`ifdef AVALON_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RDATA: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ls_rdata;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs; reset drops the bus strobes at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
`ifdef AVALON_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
`ifdef AVALON_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Latched request shape used only for load extraction; pure data, no reset
  always_ff @(posedge clk) begin
    size_q   <= size_d;
    signed_q <= signed_d;
    off_q    <= off_d;
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule
